// File: rtl/sample_arbiter.sv
// sample_arbiter: round-robin arbiter that moves one sample at a time from
// five acquisition queues (DIN, ADC0, ADC1, CADC0, CADC1) into the host write
// queue. Each sample becomes a tagged byte packet:
//   DIN     : header, data[7:0]
//   ADC/CADC: header, data[15:8], data[7:0]
// Header = {tag[2:0], low5}. low5 is a packet sequence counter when the
// SAMPLE_ARB_SEQ_EN macro is defined; otherwise it is 5'b00000.
module sample_arbiter #(
    parameter int unsigned ADC_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [4:0]           src_mask,
    input  logic [4:0]           src_empty,
    output logic [4:0]           src_pop,
    input  logic [7:0]           din_data,
    input  logic [4*ADC_W-1:0]   adc_data,
    input  logic                 wr_full,
    output logic                 wr_ld,
    output logic [7:0]           wr_data,
    output logic                 busy,
    output logic [2:0]           grant_tag
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_HI,
        ST_LO
    } state_t;

    state_t      r_state;
    logic [2:0]  r_last;
    logic [2:0]  r_tag;
    logic [15:0] r_buf;
`ifdef SAMPLE_ARB_SEQ_EN
    logic [4:0]  r_seq;
`endif

    logic [4:0]  w_req;
    logic        w_grant_vld;
    logic [2:0]  w_grant_idx;
    logic [2:0]  w_grant_tag;
    logic [15:0] w_head;

    assign w_req       = src_mask & ~src_empty;
    assign w_grant_tag = w_grant_idx + 3'd1;

    // Round-robin search: first requester after the last granted index.
    always_comb begin
        logic [2:0] v_idx;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        v_idx       = '0;
        for (int unsigned k = 1; k <= 5; k++) begin
            v_idx = 3'((32'(r_last) + k) % 5);
            if (!w_grant_vld && w_req[v_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_idx;
            end
        end
    end

    // Head word of the selected source, zero-extended to the 16-bit buffer.
    always_comb begin
        w_head = '0;
        case (w_grant_idx)
            3'd0:    w_head = {8'h00, din_data};
            3'd1:    w_head = 16'(adc_data[0*ADC_W +: ADC_W]);
            3'd2:    w_head = 16'(adc_data[1*ADC_W +: ADC_W]);
            3'd3:    w_head = 16'(adc_data[2*ADC_W +: ADC_W]);
            3'd4:    w_head = 16'(adc_data[3*ADC_W +: ADC_W]);
            default: w_head = '0;
        endcase
    end

    // Packet FSM with registered outputs; each byte waits for wr_full low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= 3'd4;
            r_tag     <= '0;
            r_buf     <= '0;
            src_pop   <= '0;
            wr_ld     <= 1'b0;
            wr_data   <= '0;
            busy      <= 1'b0;
            grant_tag <= '0;
`ifdef SAMPLE_ARB_SEQ_EN
            r_seq     <= '0;
`endif
        end else begin
            src_pop <= '0;
            wr_ld   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run && w_grant_vld) begin
                        src_pop   <= 5'(5'b00001 << w_grant_idx);
                        r_buf     <= w_head;
                        r_tag     <= w_grant_tag;
                        r_last    <= w_grant_idx;
                        grant_tag <= w_grant_tag;
                        busy      <= 1'b1;
                        r_state   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (!wr_full) begin
                        wr_ld   <= 1'b1;
`ifdef SAMPLE_ARB_SEQ_EN
                        wr_data <= {r_tag, r_seq};
                        r_seq   <= r_seq + 5'd1;
`else
                        wr_data <= {r_tag, 5'b00000};
`endif
                        r_state <= (r_tag == 3'd1) ? ST_LO : ST_HI;
                    end
                end
                ST_HI: begin
                    if (!wr_full) begin
                        wr_ld   <= 1'b1;
                        wr_data <= r_buf[15:8];
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (!wr_full) begin
                        wr_ld     <= 1'b1;
                        wr_data   <= r_buf[7:0];
                        busy      <= 1'b0;
                        grant_tag <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    grant_tag <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_arbiter.sv
// tb_sample_arbiter: randomized and directed bench for sample_arbiter.
// Source queues are modelled as bench queues; a packet-level reference model
// predicts pops, bytes, busy and grant_tag each cycle.
module tb_sample_arbiter;

    localparam int unsigned ADC_W = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 run;
    logic [4:0]           src_mask;
    logic [4:0]           src_empty;
    logic [4:0]           src_pop;
    logic [7:0]           din_data;
    logic [4*ADC_W-1:0]   adc_data;
    logic                 wr_full;
    logic                 wr_ld;
    logic [7:0]           wr_data;
    logic                 busy;
    logic [2:0]           grant_tag;

    sample_arbiter #(.ADC_W(ADC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .src_mask  (src_mask),
        .src_empty (src_empty),
        .src_pop   (src_pop),
        .din_data  (din_data),
        .adc_data  (adc_data),
        .wr_full   (wr_full),
        .wr_ld     (wr_ld),
        .wr_data   (wr_data),
        .busy      (busy),
        .grant_tag (grant_tag)
    );

    always #5 clk = ~clk;

    // Source queues (index 0 = DIN, 1..4 = ADC0..CADC1)
    logic [15:0] srcq [5][$];

    // Reference model state
    logic [7:0]  m_bytes[$];
    int          m_last;
    int          m_tag;
    int          m_seq;
    logic [4:0]  exp_pop;
    logic        exp_ld;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic [2:0]  exp_tag;

    // Observations
    logic [7:0]  obs_bytes[$];
    int          pop_cnt[5];
    int          busy_cnt;
    logic [4:0]  first_pop;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_last = 4;
        m_tag  = 0;
        m_seq  = 0;
    endtask

    task automatic drive_srcs();
        logic [15:0] h;
        src_empty = '1;
        din_data  = '0;
        adc_data  = '0;
        for (int i = 0; i < 5; i++) begin
            if (srcq[i].size() != 0) begin
                src_empty[i] = 1'b0;
                h = srcq[i][0];
                if (i == 0) din_data = h[7:0];
                else adc_data[(i-1)*ADC_W +: ADC_W] = h[ADC_W-1:0];
            end
        end
    endtask

    // One clock of the packet-level model, using the inputs about to be sampled.
    task automatic model_step();
        logic [15:0]        v;
        logic [4*ADC_W-1:0] sh;
        logic [7:0]         hdr;
        int                 g;
        bit                 found;
        exp_pop  = '0;
        exp_ld   = 1'b0;
        exp_data = '0;
        if (m_bytes.size() != 0) begin
            if (!wr_full) begin
                exp_ld   = 1'b1;
                exp_data = m_bytes.pop_front();
            end
        end else if (run) begin
            found = 0;
            g = 0;
            for (int k = 1; k <= 5; k++) begin
                if (!found && src_mask[(m_last + k) % 5] && !src_empty[(m_last + k) % 5]) begin
                    found = 1;
                    g = (m_last + k) % 5;
                end
            end
            if (found) begin
                exp_pop = 5'(1 << g);
                if (g == 0) v = {8'h00, din_data};
                else begin
                    sh = adc_data >> ((g - 1) * ADC_W);
                    v  = 16'(sh[ADC_W-1:0]);
                end
`ifdef SAMPLE_ARB_SEQ_EN
                hdr   = {3'(g + 1), 5'(m_seq)};
                m_seq = (m_seq + 1) % 32;
`else
                hdr = {3'(g + 1), 5'b00000};
`endif
                m_bytes.push_back(hdr);
                if (g != 0) m_bytes.push_back(v[15:8]);
                m_bytes.push_back(v[7:0]);
                m_tag  = g + 1;
                m_last = g;
            end
        end
        exp_busy = (m_bytes.size() != 0);
        exp_tag  = exp_busy ? 3'(m_tag) : 3'd0;
    endtask

    task automatic cycle();
        drive_srcs();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        chk_eq("src_pop", 32'(src_pop), 32'(exp_pop));
        chk_eq("wr_ld", 32'(wr_ld), 32'(exp_ld));
        if (exp_ld) chk_eq("wr_data", 32'(wr_data), 32'(exp_data));
        chk_eq("busy", 32'(busy), 32'(exp_busy));
        chk_eq("grant_tag", 32'(grant_tag), 32'(exp_tag));
        if (wr_ld) obs_bytes.push_back(wr_data);
        if (busy) busy_cnt++;
        if (src_pop != 0 && first_pop == 0) first_pop = src_pop;
        for (int i = 0; i < 5; i++) begin
            if (src_pop[i]) begin
                pop_cnt[i]++;
                if (srcq[i].size() != 0) void'(srcq[i].pop_front());
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        for (int i = 0; i < 5; i++) pop_cnt[i] = 0;
        busy_cnt  = 0;
        first_pop = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_pop"},  32'(src_pop), 32'd0);
        chk_eq({tag, "_ld"},   32'(wr_ld), 32'd0);
        chk_eq({tag, "_data"}, 32'(wr_data), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
        chk_eq({tag, "_tag"},  32'(grant_tag), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         pos;
        int         tags[6];
        rst_n    = 1'b0;
        run      = 1'b0;
        src_mask = '0;
        wr_full  = 1'b0;
        model_reset();
        clear_obs();
        drive_srcs();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // All five sources pending after reset: DIN, ADC0, ADC1, CADC0, CADC1, DIN
        clear_obs();
        srcq[0].push_back(16'h0011);
        srcq[0].push_back(16'h0022);
        for (int i = 1; i < 5; i++) srcq[i].push_back(16'($urandom_range(0, (1 << ADC_W) - 1)));
        src_mask = 5'b11111;
        run      = 1'b1;
        run_cycles(30);
        tags = '{1, 2, 3, 4, 5, 1};
        pos = 0;
        chk_eq("rr_nbytes", 32'(obs_bytes.size()), 32'd16);
        for (int p = 0; p < 6; p++) begin
            if (pos < obs_bytes.size()) begin
                b = obs_bytes[pos];
                chk_eq("rr_tag", 32'(b[7:5]), 32'(tags[p]));
            end
            pos += (tags[p] == 1) ? 2 : 3;
        end
        chk_eq("rr_pop_din", 32'(pop_cnt[0]), 32'd2);
        for (int i = 1; i < 5; i++) chk_eq("rr_pop_adc", 32'(pop_cnt[i]), 32'd1);

        // 33 DIN packets: header counter (or fixed 8'h20 header)
        clear_obs();
        for (int p = 0; p < 33; p++) srcq[0].push_back(16'($urandom_range(0, 255)));
        src_mask = 5'b00001;
        run_cycles(105);
        chk_eq("din33_nbytes", 32'(obs_bytes.size()), 32'd66);
        for (int p = 0; p < 33; p++) begin
            if (2 * p < obs_bytes.size()) begin
                b = obs_bytes[2 * p];
`ifdef SAMPLE_ARB_SEQ_EN
                chk_eq("seq_hdr", 32'(b), 32'({3'b001, 5'((6 + p) % 32)}));
`else
                chk_eq("din_hdr", 32'(b), 32'h20);
`endif
            end
        end

        // Single ADC0 sample 10'h2A5
        clear_obs();
        srcq[1].push_back(16'h02A5);
        src_mask = 5'b00010;
        run_cycles(8);
        chk_eq("adc0_nbytes", 32'(obs_bytes.size()), 32'd3);
        if (obs_bytes.size() == 3) begin
            b = obs_bytes[0];
            chk_eq("adc0_hdr_tag", 32'(b[7:5]), 32'd2);
            chk_eq("adc0_hi", 32'(obs_bytes[1]), 32'h02);
            chk_eq("adc0_lo", 32'(obs_bytes[2]), 32'hA5);
        end
        chk_eq("adc0_pops", 32'(pop_cnt[1]), 32'd1);
        chk_eq("adc0_busy_cycles", 32'(busy_cnt), 32'd3);

        // Single DIN sample 8'h5C
        clear_obs();
        srcq[0].push_back(16'h005C);
        src_mask = 5'b00001;
        run_cycles(6);
        chk_eq("din_nbytes", 32'(obs_bytes.size()), 32'd2);
        if (obs_bytes.size() == 2) chk_eq("din_lo", 32'(obs_bytes[1]), 32'h5C);
        chk_eq("din_busy_cycles", 32'(busy_cnt), 32'd2);

        // Back-pressure during HI of a CADC1 packet with sample 10'h3FF
        clear_obs();
        srcq[4].push_back(16'h03FF);
        src_mask = 5'b10000;
        wr_full  = 1'b0;
        run_cycles(2);
        wr_full = 1'b1;
        run_cycles(3);
        wr_full = 1'b0;
        run_cycles(5);
        chk_eq("bp_nbytes", 32'(obs_bytes.size()), 32'd3);
        if (obs_bytes.size() == 3) begin
            chk_eq("bp_hi", 32'(obs_bytes[1]), 32'h03);
            chk_eq("bp_lo", 32'(obs_bytes[2]), 32'hFF);
        end
        chk_eq("bp_pops", 32'(pop_cnt[4]), 32'd1);

        // Reset pulsed while a CADC0 packet sits in HI
        clear_obs();
        srcq[3].push_back(16'h0155);
        src_mask = 5'b01000;
        run_cycles(2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        model_reset();
        srcq[0].push_back(16'h0077);
        srcq[2].push_back(16'h0123);
        src_mask = 5'b00111;
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        rst_n = 1'b1;
        clear_obs();
        run_cycles(12);
        chk_eq("rst_first_pop", 32'(first_pop), 32'h01);
        chk_eq("rst_nbytes", 32'(obs_bytes.size()), 32'd5);
        if (obs_bytes.size() != 0) begin
            b = obs_bytes[0];
            chk_eq("rst_first_tag", 32'(b[7:5]), 32'd1);
        end

        // Randomized traffic with back-pressure and mask/run changes
        for (int c = 0; c < 1500; c++) begin
            run     = ($urandom_range(0, 9) != 0);
            wr_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) src_mask = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                if (srcq[i].size() < 3 && $urandom_range(0, 3) == 0)
                    srcq[i].push_back(16'($urandom_range(0, (i == 0) ? 255 : (1 << ADC_W) - 1)));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
